// File: rtl/bjack_pkg.sv
// Shared types and constants for the blackjack table controller.
// Holds the one-hot state encoding, card/hand widths and card limits.
package bjack_pkg;

  localparam int CARD_W      = 4;
  localparam int HAND_W      = 5;
  localparam int CARD_MIN    = 1;
  localparam int CARD_MAX    = 11;
  localparam int COOL_CYCLES = 2;

  typedef enum logic [7:0] {
    S_IDLE  = 8'b0000_0001,
    S_CLEAR = 8'b0000_0010,
    S_ARB   = 8'b0000_0100,
    S_FETCH = 8'b0000_1000,
    S_DEAL  = 8'b0001_0000,
    S_COOL  = 8'b0010_0000,
    S_SCORE = 8'b0100_0000,
    S_DONE  = 8'b1000_0000
  } state_t;

  function automatic logic card_legal(
    input logic [CARD_W-1:0] c
  );
    return (c >= CARD_W'(CARD_MIN)) &&
           (c <= CARD_W'(CARD_MAX));
  endfunction

endpackage

// File: rtl/bjack_rr_arb.sv
// N-way round-robin arbiter: grants the first requester after ptr.
// Ports: req/ptr/en in; one-hot gnt and binary idx out.
module bjack_rr_arb #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx
);

  always_comb begin : p_pick
    int   j;
    logic hit;
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j   = 0;
    // Scan ptr+1 .. ptr+N so the last winner has lowest priority.
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bjack_table.sv
// Blackjack table controller: deals deck cards round-robin to players.
// Ports: deck handshake, per-player flags/hands, card bus, results.
module bjack_table
  import bjack_pkg::*;
#(
  parameter int N_PLAYERS = 4,
  parameter int ID_W      = 2
) (
  input  logic                        CLOCK,
  input  logic                        NEW_G,
  input  logic                        START,
  input  logic [CARD_W-1:0]           DECK_CARD,
  input  logic                        DECK_VLD,
  output logic                        DECK_REQ,
  input  logic [N_PLAYERS-1:0]        P_NEXT_C,
  input  logic [N_PLAYERS-1:0]        P_HOLD,
  input  logic [N_PLAYERS-1:0]        P_BUST,
  input  logic [HAND_W*N_PLAYERS-1:0] P_HAND,
  output logic [N_PLAYERS-1:0]        P_NEW_G,
  output logic [CARD_W-1:0]           CARD,
  output logic [N_PLAYERS-1:0]        NEW_C,
  output logic [ID_W-1:0]             GRANT_ID,
  output logic                        DONE,
  output logic [N_PLAYERS-1:0]        WINNER,
  output logic [HAND_W-1:0]           BEST
);

  localparam logic [1:0] COOL_LAST =
    2'(COOL_CYCLES - 1);
  localparam logic [ID_W-1:0] PTR_RST =
    ID_W'(N_PLAYERS - 1);

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        gid_q, gid_d;
  logic [N_PLAYERS-1:0]   gnt_q, gnt_d;
  logic [CARD_W-1:0]      card_q, card_d;
  logic                   req_q, req_d;
  logic [N_PLAYERS-1:0]   newc_q, newc_d;
  logic                   done_q, done_d;
  logic [N_PLAYERS-1:0]   win_q, win_d;
  logic [HAND_W-1:0]      best_q, best_d;
  logic [1:0]             cool_q, cool_d;

  logic [N_PLAYERS-1:0]   arb_gnt;
  logic [ID_W-1:0]        arb_idx;
  logic                   settled;
  logic [HAND_W-1:0]      sc_best;
  logic [N_PLAYERS-1:0]   sc_win;

  bjack_rr_arb #(
    .N    (N_PLAYERS),
    .ID_W (ID_W)
  ) u_arb (
    .req (P_NEXT_C),
    .ptr (ptr_q),
    .en  (state_q == S_ARB),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign settled = &(P_HOLD | P_BUST);

  // Best total among holders; busted players never qualify.
  always_comb begin
    sc_best = '0;
    sc_win  = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (P_HOLD[i] &&
          P_HAND[i*HAND_W +: HAND_W] > sc_best)
        sc_best = P_HAND[i*HAND_W +: HAND_W];
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      sc_win[i] = P_HOLD[i] &&
        (P_HAND[i*HAND_W +: HAND_W] == sc_best);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    gnt_d   = gnt_q;
    card_d  = card_q;
    req_d   = 1'b0;
    newc_d  = '0;
    done_d  = done_q;
    win_d   = win_q;
    best_d  = best_q;
    cool_d  = cool_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_CLEAR;
          done_d  = 1'b0;
          win_d   = '0;
          best_d  = '0;
        end
      end
      S_CLEAR: state_d = S_ARB;
      S_ARB: begin
        if (settled) begin
          state_d = S_SCORE;
        end else if (|arb_gnt) begin
          ptr_d   = arb_idx;
          gid_d   = arb_idx;
          gnt_d   = arb_gnt;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Illegal cards are consumed but dropped.
        req_d = 1'b1;
        if (DECK_VLD && req_q &&
            card_legal(DECK_CARD)) begin
          card_d  = DECK_CARD;
          req_d   = 1'b0;
          newc_d  = gnt_q;
          state_d = S_DEAL;
        end
      end
      S_DEAL: begin
        cool_d  = '0;
        state_d = S_COOL;
      end
      S_COOL: begin
        if (cool_q == COOL_LAST)
          state_d = S_ARB;
        else
          cool_d = cool_q + 2'd1;
      end
      S_SCORE: begin
        best_d  = sc_best;
        win_d   = sc_win;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (NEW_G) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      gid_q   <= '0;
      gnt_q   <= '0;
      card_q  <= '0;
      req_q   <= 1'b0;
      newc_q  <= '0;
      done_q  <= 1'b0;
      win_q   <= '0;
      best_q  <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      gnt_q   <= gnt_d;
      card_q  <= card_d;
      req_q   <= req_d;
      newc_q  <= newc_d;
      done_q  <= done_d;
      win_q   <= win_d;
      best_q  <= best_d;
      cool_q  <= cool_d;
    end
  end

  assign P_NEW_G =
    {N_PLAYERS{NEW_G | (state_q == S_CLEAR)}};
  assign DECK_REQ = req_q;
  assign CARD     = card_q;
  assign NEW_C    = newc_q;
  assign GRANT_ID = gid_q;
  assign DONE     = done_q;
  assign WINNER   = win_q;
  assign BEST     = best_q;

endmodule

// File: tb/tb_bjack_table.sv
// Bench for bjack_table: player/deck models, game-level predictor,
// and a scoreboard monitor comparing deals and round results.
module tb_bjack_table;

  logic        CLOCK = 1'b0;
  logic        NEW_G = 1'b1;
  logic        START = 1'b0;
  logic [3:0]  DECK_CARD = '0;
  logic        DECK_VLD = 1'b0;
  logic        DECK_REQ;
  logic [3:0]  P_NEXT_C = '0;
  logic [3:0]  P_HOLD = '0;
  logic [3:0]  P_BUST = '0;
  logic [19:0] P_HAND = '0;
  logic [3:0]  P_NEW_G;
  logic [3:0]  CARD;
  logic [3:0]  NEW_C;
  logic [1:0]  GRANT_ID;
  logic        DONE;
  logic [3:0]  WINNER;
  logic [4:0]  BEST;

  bjack_table #(.N_PLAYERS(4), .ID_W(2)) dut (
    .CLOCK     (CLOCK),
    .NEW_G     (NEW_G),
    .START     (START),
    .DECK_CARD (DECK_CARD),
    .DECK_VLD  (DECK_VLD),
    .DECK_REQ  (DECK_REQ),
    .P_NEXT_C  (P_NEXT_C),
    .P_HOLD    (P_HOLD),
    .P_BUST    (P_BUST),
    .P_HAND    (P_HAND),
    .P_NEW_G   (P_NEW_G),
    .CARD      (CARD),
    .NEW_C     (NEW_C),
    .GRANT_ID  (GRANT_ID),
    .DONE      (DONE),
    .WINNER    (WINNER),
    .BEST      (BEST)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [3:0] nc;
    logic [3:0] cd;
  } deal_t;
  typedef struct {
    logic [4:0] best;
    logic [3:0] win;
  } res_t;

  int         total = 0;
  int         bad = 0;
  deal_t      deal_q[$];
  res_t       res_q[$];
  logic [3:0] deck[$];
  int         di = 0;
  bit         deck_always = 1'b1;
  int         thr[4] = '{21, 21, 21, 21};
  int         hand[4] = '{0, 0, 0, 0};
  int         mptr = 3;
  bit         gap_chk = 1'b0;
  int         last_nc = -1;
  int         cyc = 0;
  bit         first_seen = 1'b0;
  logic [3:0] first_nc = '0;
  logic       done_prev = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Deck: presents deck[di]; an entry is used up on VLD & REQ.
  initial begin
    forever begin
      @(posedge CLOCK);
      if (DECK_VLD && DECK_REQ) di++;
      @(negedge CLOCK);
      DECK_VLD = (di < deck.size()) &&
        (deck_always || $urandom_range(0, 3) != 0);
      DECK_CARD = (di < deck.size()) ? deck[di] : 4'd0;
    end
  end

  // Players: draw below threshold, hold at/above it, bust over 21.
  task automatic drive_players();
    for (int i = 0; i < 4; i++) begin
      P_HAND[i*5 +: 5] = 5'(hand[i]);
      P_NEXT_C[i] = hand[i] < thr[i];
      P_HOLD[i] = hand[i] >= thr[i] && hand[i] <= 21;
      P_BUST[i] = hand[i] > 21;
    end
  endtask

  initial begin
    logic [3:0] pn, nc, cd;
    drive_players();
    forever begin
      @(posedge CLOCK);
      pn = P_NEW_G;
      nc = NEW_C;
      cd = CARD;
      @(negedge CLOCK);
      for (int i = 0; i < 4; i++) begin
        if (pn[i]) hand[i] = 0;
        else if (nc[i]) hand[i] = hand[i] + int'(cd);
      end
      drive_players();
    end
  end

  // Game-level prediction of one round from thresholds and deck.
  task automatic predict();
    int h[4];
    int k, p, c;
    bit any;
    logic [4:0] b;
    logic [3:0] w;
    deal_t d;
    res_t r;
    h = '{0, 0, 0, 0};
    k = 0;
    for (int g = 0; g < 200; g++) begin
      any = 1'b0;
      for (int i = 0; i < 4; i++)
        if (h[i] < thr[i]) any = 1'b1;
      if (!any) break;
      p = -1;
      for (int s = 1; s <= 4; s++) begin
        c = (mptr + s) % 4;
        if (p < 0 && h[c] < thr[c]) p = c;
      end
      while (k < deck.size() &&
             (deck[k] < 1 || deck[k] > 11)) k++;
      if (k >= deck.size()) break;
      h[p] = h[p] + int'(deck[k]);
      d.nc = 4'b0001 << p;
      d.cd = deck[k];
      deal_q.push_back(d);
      k++;
      mptr = p;
    end
    b = '0;
    for (int i = 0; i < 4; i++)
      if (h[i] >= thr[i] && h[i] <= 21 && h[i] > int'(b))
        b = 5'(h[i]);
    for (int i = 0; i < 4; i++)
      w[i] = h[i] >= thr[i] && h[i] <= 21 && h[i] == int'(b);
    r.best = b;
    r.win = w;
    res_q.push_back(r);
  endtask

  // Scoreboard monitor.
  initial begin
    deal_t d;
    res_t r;
    forever begin
      @(negedge CLOCK);
      cyc++;
      if (NEW_C != 4'd0) begin
        chk("newc_onehot", 32'($onehot(NEW_C)), 1);
        if (!first_seen) begin
          first_nc = NEW_C;
          first_seen = 1'b1;
        end
        if (gap_chk && last_nc >= 0)
          chk("deal_gap", cyc - last_nc, 5);
        last_nc = cyc;
        if (deal_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL deal_extra: got NEW_C=%b want none",
                   NEW_C);
        end else begin
          d = deal_q.pop_front();
          chk("deal_newc", NEW_C, d.nc);
          chk("deal_card", CARD, d.cd);
        end
      end
      if (DONE && !done_prev) begin
        if (res_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_extra: got DONE=1 want 0");
        end else begin
          r = res_q.pop_front();
          chk("res_best", BEST, r.best);
          chk("res_winner", WINNER, r.win);
        end
      end
      done_prev = DONE;
    end
  end

  task automatic begin_round(input bit av, input bit gap);
    predict();
    di = 0;
    deck_always = av;
    gap_chk = gap;
    last_nc = -1;
    first_seen = 1'b0;
    @(negedge CLOCK);
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  task automatic run_round(input bit av, input bit gap);
    int n;
    begin_round(av, gap);
    n = 0;
    while (!DONE && n < 3000) begin
      @(negedge CLOCK);
      n++;
    end
    chk("round_done", DONE, 1);
    @(negedge CLOCK);
    chk("deals_left", deal_q.size(), 0);
    chk("results_left", res_q.size(), 0);
    gap_chk = 1'b0;
  endtask

  task automatic rand_deck(input bit legal_only);
    deck.delete();
    for (int i = 0; i < 200; i++)
      deck.push_back(legal_only ?
        4'($urandom_range(1, 11)) :
        4'($urandom_range(0, 15)));
  endtask

  initial begin
    int n, cnt;
    // Reset held two cycles.
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_deck_req", DECK_REQ, 0);
    chk("rst_new_c", NEW_C, 0);
    chk("rst_card", CARD, 0);
    chk("rst_done", DONE, 0);
    chk("rst_winner", WINNER, 0);
    chk("rst_best", BEST, 0);
    chk("rst_grant_id", GRANT_ID, 0);
    chk("rst_p_new_g", P_NEW_G, 4'hF);
    NEW_G = 1'b0;
    mptr = 3;

    // Tie at 20 with one bust.
    thr = '{20, 20, 20, 18};
    deck = '{4'd10, 4'd10, 4'd10, 4'd9, 4'd10,
             4'd10, 4'd2, 4'd9, 4'd11};
    run_round(1'b1, 1'b0);
    chk("tie_best", BEST, 20);
    chk("tie_winner", WINNER, 4'b0011);
    chk("tie_done", DONE, 1);

    // Everybody busts.
    thr = '{21, 21, 21, 21};
    deck = '{4'd11, 4'd11, 4'd11, 4'd11, 4'd11,
             4'd11, 4'd11, 4'd11};
    run_round(1'b1, 1'b0);
    chk("bust_best", BEST, 0);
    chk("bust_winner", WINNER, 0);
    chk("bust_done", DONE, 1);

    // NEW_G together with START: START must be ignored.
    @(negedge CLOCK);
    NEW_G = 1'b1;
    START = 1'b1;
    @(negedge CLOCK);
    NEW_G = 1'b0;
    START = 1'b0;
    mptr = 3;
    chk("ng_start_done", DONE, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      chk("ng_start_req", DECK_REQ, 0);
    end

    // Illegal cards 0 and 13 dropped before 7.
    thr = '{7, 1, 1, 1};
    deck = '{4'd0, 4'd13, 4'd7, 4'd5, 4'd6, 4'd8};
    begin_round(1'b1, 1'b0);
    n = 0;
    while (!DECK_REQ && n < 20) begin
      @(negedge CLOCK);
      n++;
    end
    chk("drop_req0", DECK_REQ, 1);
    @(negedge CLOCK);
    chk("drop_req1", DECK_REQ, 1);
    @(negedge CLOCK);
    chk("drop_req2", DECK_REQ, 1);
    @(negedge CLOCK);
    chk("drop_newc", NEW_C, 4'b0001);
    chk("drop_card", CARD, 7);
    n = 0;
    while (!DONE && n < 500) begin
      @(negedge CLOCK);
      n++;
    end
    chk("drop_done", DONE, 1);
    @(negedge CLOCK);
    chk("drop_left", deal_q.size() + res_q.size(), 0);

    // Round-robin with deck always valid: 5-cycle spacing.
    thr = '{21, 21, 21, 21};
    rand_deck(1'b1);
    run_round(1'b1, 1'b1);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++)
        thr[i] = $urandom_range(10, 21);
      rand_deck(1'b0);
      run_round(1'b0, 1'b0);
    end

    // Abort during the second deal.
    thr = '{21, 21, 21, 21};
    rand_deck(1'b1);
    begin_round(1'b1, 1'b0);
    n = 0;
    cnt = 0;
    while (cnt < 2 && n < 500) begin
      @(negedge CLOCK);
      n++;
      if (NEW_C != 4'd0) cnt++;
    end
    chk("abort_reach", cnt, 2);
    NEW_G = 1'b1;
    @(negedge CLOCK);
    chk("abort_newc", NEW_C, 0);
    chk("abort_req", DECK_REQ, 0);
    chk("abort_gid", GRANT_ID, 0);
    chk("abort_card", CARD, 0);
    chk("abort_p_new_g", P_NEW_G, 4'hF);
    NEW_G = 1'b0;
    deal_q.delete();
    res_q.delete();
    mptr = 3;

    for (int i = 0; i < 4; i++)
      thr[i] = $urandom_range(12, 21);
    rand_deck(1'b0);
    run_round(1'b0, 1'b0);
    chk("after_abort_first", first_nc, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
